reg_delay: RTL and testbench

//   Parameterised fixed-length register delay line (shift register) for DSP

---
 rtl/reg_delay.sv | 40 ++++
 tb/tb_reg_delay.sv | 137 +++++++++++++
 2 files changed

// File: rtl/reg_delay.sv
// Fixed-length, clock-enabled register delay line for aligning DSP pipeline branches.
// len==0 degenerates to a wire; otherwise dout is the last of len gated registers.
module reg_delay #(
    parameter int dw  = 36,
    parameter int len = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          gate,
    input  logic [dw-1:0] din,
    output logic [dw-1:0] dout
);

    generate
        if (len == 0) begin : g_passthru
            // Control inputs are deliberately ignored in the pass-through build.
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, reset, gate};
            assign dout = din;
        end else begin : g_pipe
            logic [dw-1:0] sr [len] = '{default: '0};

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < len; k++) begin
                        sr[k] <= '0;
                    end
                end else if (gate) begin
                    sr[0] <= din;
                    for (int k = 1; k < len; k++) begin
                        sr[k] <= sr[k-1];
                    end
                end
            end

            assign dout = sr[len-1];
        end
    endgenerate

endmodule

// File: tb/tb_reg_delay.sv
// Self-checking bench for reg_delay: len=6, len=1 and len=0 instances
// compared against queue-based models of "the sample taken len gate pulses ago".
module tb_reg_delay;

    localparam int DW = 36;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          gate = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout6;
    logic [DW-1:0] dout1;
    logic [DW-1:0] dout0;

    int nVectors = 0;
    int nMiscompares = 0;

    logic [DW-1:0] q6[$];
    logic [DW-1:0] q1[$];

    always #5 clk = ~clk;

    reg_delay #(.dw(DW), .len(6)) dut6 (
        .clk(clk), .reset(reset), .gate(gate), .din(din), .dout(dout6)
    );
    reg_delay #(.dw(DW), .len(1)) dut1 (
        .clk(clk), .reset(reset), .gate(gate), .din(din), .dout(dout1)
    );
    reg_delay #(.dw(DW), .len(0)) dut0 (
        .clk(clk), .reset(reset), .gate(gate), .din(din), .dout(dout0)
    );

    task automatic checkValue(input string tag, input logic [DW-1:0] obs,
                              input logic [DW-1:0] exp);
        nVectors++;
        assert (obs === exp)
        else begin
            nMiscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic flushModels();
        q6.delete();
        q1.delete();
        for (int i = 0; i < 6; i++) q6.push_back('0);
        q1.push_back('0);
    endtask

    task automatic checkOutput();
        checkValue("len6", dout6, q6[0]);
        checkValue("len1", dout1, q1[0]);
    endtask

    // Drive one cycle, check the combinational instance, then advance the
    // models exactly as the edge should and check the registered instances.
    task automatic applyStimulus(input logic [DW-1:0] d, input logic g, input logic r);
        din   = d;
        gate  = g;
        reset = r;
        #1;
        checkValue("len0", dout0, d);
        @(posedge clk);
        if (r) begin
            flushModels();
        end else if (g) begin
            q6.push_back(d);
            void'(q6.pop_front());
            q1.push_back(d);
            void'(q1.pop_front());
        end
        #1;
        checkOutput();
    endtask

    initial begin
        logic [DW-1:0] cnt;
        logic [DW-1:0] ones;
        logic [DW-1:0] rnd;
        flushModels();
        cnt  = '0;
        ones = '1;

        $display("[TB] power-up state");
        #1;
        checkOutput();

        $display("[TB] free-running gate, counting din");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(cnt, 1'b1, 1'b0);
            cnt++;
        end

        $display("[TB] long reset then release");
        for (int i = 0; i < 100; i++) begin
            applyStimulus(cnt, 1'b1, 1'b1);
            cnt++;
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(cnt, 1'b1, 1'b0);
            cnt++;
        end

        $display("[TB] alternating gate");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(cnt, (i % 2) == 0, 1'b0);
            cnt++;
        end

        $display("[TB] single-cycle reset mid-stream, gate low during reset");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(cnt, 1'b1, 1'b0);
            cnt++;
        end
        applyStimulus(cnt, 1'b0, 1'b1);
        cnt++;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(cnt, 1'b1, 1'b0);
            cnt++;
        end

        $display("[TB] full-width alternating pattern");
        for (int i = 0; i < 16; i++) begin
            applyStimulus((i % 2) == 0 ? ones : '0, 1'b1, 1'b0);
        end

        $display("[TB] random data, gate and occasional reset");
        for (int i = 0; i < 200; i++) begin
            rnd = {$urandom(), $urandom()};
            applyStimulus(rnd, $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
